// File: rtl/apb_req_master.sv
// apb_req_master: valid/ready register-access request port bridged onto an APB3 master.
//
// Ports:
//   pclk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (req_ready high only when idle)
//   req_write/req_addr/req_wdata   request direction, byte address, write data
//   rsp_valid/rsp_ready            response handshake, response held until consumed
//   rsp_rdata/rsp_err              read data (0 for writes/errors), error flag
//   paddr/psel/penable/pwrite/pwdata  APB master outputs (all registered)
//   prdata/pready/pslverr          APB slave returns
//
// Optional feature: define APB_MST_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT cycles with pready low. Without it ACCESS waits for pready forever.
module apb_req_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_err_q;
`ifdef APB_MST_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
`endif
  // gated with rst_n so no request is accepted while reset is held
  assign req_ready = rst_n && (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MST_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          pwrite_q    <= req_write;
          paddr_q     <= req_addr;
          pwdata_q    <= req_wdata;
          rsp_rdata_q <= '0;
          // misaligned requests never reach the bus
          if (req_addr[1:0] != 2'b00) begin
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            rsp_err_q <= 1'b0;
            psel_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_MST_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: if (pready) begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= pslverr;
          rsp_rdata_q <= (pwrite_q || pslverr) ? '0 : prdata;
          state_q     <= RESP;
        end
`ifdef APB_MST_TIMEOUT_EN
        // this is the TIMEOUT-th stalled cycle: give up
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
`endif
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: directed scoreboard bench for apb_req_master.
module tb_apb_req_master;
  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata = '0;
  logic        pready = 1'b1, pslverr = 1'b0;
  int n_cmp = 0, n_err = 0;
  logic [32:0] exp_q[$];

  apb_req_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(8)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // present a request, wait for acceptance, optionally queue its expected response
  task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic push, input logic e, input logic [31:0] r);
    int k = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && k < 20) begin tick; k++; end
    if (!req_ready) chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    if (push) exp_q.push_back({e, r});
    tick;
    req_valid = 1'b0;
  endtask

  always @(negedge pclk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_rsp: got err=%b rdata=%h expected none", rsp_err, rsp_rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("sb_rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
        chk("sb_rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_psel", {31'b0, psel}, 0);
    chk("rst_penable", {31'b0, penable}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_paddr", {16'b0, paddr}, 0);
    chk("rst_pwdata", pwdata, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("idle_req_ready", {31'b0, req_ready}, 1);
    // 1: write, zero-wait
    pready = 1'b1;
    send(1'b1, 16'h0104, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    chk("t1_psel", {31'b0, psel}, 1);
    chk("t1_setup_penable", {31'b0, penable}, 0);
    chk("t1_paddr", {16'b0, paddr}, 32'h0104);
    tick;
    chk("t1_penable", {31'b0, penable}, 1);
    chk("t1_pwdata", pwdata, 32'hDEADBEEF);
    chk("t1_pwrite", {31'b0, pwrite}, 1);
    tick;
    chk("t1_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("t1_psel_drop", {31'b0, psel}, 0);
    tick;
    chk("t1_idle_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("t1_paddr_hold", {16'b0, paddr}, 32'h0104);
    // 2: read, zero-wait
    prdata = 32'h0176_5A03;
    send(1'b0, 16'h0100, 32'h0, 1'b1, 1'b0, 32'h0176_5A03);
    tick;
    chk("t2_pwrite", {31'b0, pwrite}, 0);
    tick;
    chk("t2_rsp_valid", {31'b0, rsp_valid}, 1);
    tick;
    // 3: read with 3 wait states then slave error
    prdata = 32'h0; pready = 1'b0;
    send(1'b0, 16'h0110, 32'h0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t3_penable", {31'b0, penable}, 1);
      chk("t3_no_rsp", {31'b0, rsp_valid}, 0);
    end
    pready = 1'b1; pslverr = 1'b1;
    tick;
    chk("t3_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("t3_psel_drop", {31'b0, psel}, 0);
    pslverr = 1'b0;
    tick;
    // 4: misaligned, response held
    rsp_ready = 1'b0;
    send(1'b1, 16'h0102, 32'h1111_1111, 1'b1, 1'b1, 32'h0);
    chk("t4_psel", {31'b0, psel}, 0);
    chk("t4_rsp_valid", {31'b0, rsp_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t4_hold_valid", {31'b0, rsp_valid}, 1);
      chk("t4_hold_err", {31'b0, rsp_err}, 1);
      chk("t4_req_ready", {31'b0, req_ready}, 0);
      chk("t4_psel_hold", {31'b0, psel}, 0);
    end
    rsp_ready = 1'b1;
    tick;
    // 5: slave stuck
    pready = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
    send(1'b0, 16'h0120, 32'h0, 1'b1, 1'b1, 32'h0);
`else
    send(1'b0, 16'h0120, 32'h0, 1'b0, 1'b0, 32'h0);
`endif
    chk("t5_err_cleared", {31'b0, rsp_err}, 0);
    tick;
`ifdef APB_MST_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("t5_penable", {31'b0, penable}, 1);
      tick;
    end
    chk("t5_to_psel", {31'b0, psel}, 0);
    chk("t5_to_valid", {31'b0, rsp_valid}, 1);
    chk("t5_to_err", {31'b0, rsp_err}, 1);
    tick;
    send(1'b0, 16'h0124, 32'h0, 1'b0, 1'b0, 32'h0);
    tick; tick;
`else
    for (int i = 0; i < 100; i++) tick;
    chk("t5_stuck_psel", {31'b0, psel}, 1);
    chk("t5_stuck_penable", {31'b0, penable}, 1);
    chk("t5_stuck_valid", {31'b0, rsp_valid}, 0);
`endif
    // 6: async reset mid-ACCESS
    #3 rst_n = 1'b0;
    #1;
    chk("t6_psel", {31'b0, psel}, 0);
    chk("t6_penable", {31'b0, penable}, 0);
    chk("t6_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("t6_req_ready", {31'b0, req_ready}, 0);
    tick;
    rst_n = 1'b1; pready = 1'b1;
    tick;
    send(1'b1, 16'h0200, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
    tick;
    chk("t6_pwdata", pwdata, 32'hCAFE_F00D);
    tick;
    chk("t6_rsp_valid", {31'b0, rsp_valid}, 1);
    tick; tick;
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
